clk_gate_ctrl: RTL and testbench

Clock-enable controller that sits directly upstream of `tc_clk_gating` and drives its `en_i`. It counts consecutive idle cycles of a clock domain and shuts the clock off after a programmable threshold. It re-enables the clock on a wake request, a software force or domain activity. A settle window runs before it acknowledges the requester. The controller runs on the free-running (ungated) clock.

---
 rtl/clk_gate_ctrl.sv | 106 ++++++++++
 tb/tb_clk_gate_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/clk_gate_ctrl.sv
// Clock-enable controller for a latch-based ICG: gates the downstream clock after a
// programmable idle run and restarts it on wake request, software force or activity.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_ON   | clock running, counting consecutive idle cycles, acking requests
// ST_OFF  | clock gated, waiting for wake_req_i / sw_en_i / busy_i
// ST_WAKE | clock running again, settling WAKE_CYCLES before ST_ON
module clk_gate_ctrl #(
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sw_en_i,
    input  logic              busy_i,
    input  logic [IDLE_W-1:0] idle_thr_i,
    input  logic              wake_req_i,
    output logic              wake_ack_o,
    output logic              clk_en_o,
    output logic              gated_o
);

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int CNT_W  = (IDLE_W > WAKE_W) ? IDLE_W : WAKE_W;

    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'({IDLE_W{1'b1}});
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] thr_ext;
    logic             is_idle;
    logic             ack_nxt;

    assign thr_ext = CNT_W'(idle_thr_i);
    assign is_idle = !sw_en_i && !busy_i && !wake_req_i && (idle_thr_i != '0);
    assign cnt_inc = (cnt >= IDLE_MAX) ? IDLE_MAX : cnt + CNT_ONE;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ack_nxt   = 1'b0;
        case (state)
            ST_ON: begin
                if (is_idle) begin
                    // threshold is compared live, so a lowered value gates right away
                    if (cnt_inc >= thr_ext) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    cnt_nxt = '0;
                end
                // a held request re-arms only after the ack cycle has passed
                ack_nxt = wake_req_i && !wake_ack_o;
            end
            ST_OFF: begin
                if (wake_req_i || sw_en_i || busy_i) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt == WAKE_LAST) begin
                    state_nxt = ST_ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_ON;
                cnt_nxt   = '0;
            end
        endcase
    end

    // enable and status are registered from the next state so the ICG sees a clean flop output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_ON;
            cnt        <= '0;
            wake_ack_o <= 1'b0;
            clk_en_o   <= 1'b1;
            gated_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wake_ack_o <= ack_nxt;
            clk_en_o   <= (state_nxt != ST_OFF);
            gated_o    <= (state_nxt == ST_OFF);
        end
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: two instances (8-bit and 2-bit idle counter)
// share phased random stimulus and are checked every cycle against a reference model.
module tb_clk_gate_ctrl;

    localparam int WAKE_CYCLES = 2;

    logic       clk;
    logic       rst;
    logic       sw_en;
    logic       busy;
    logic       wake_req;
    logic [7:0] thr;
    logic [1:0] thr2;
    logic       ack_a, en_a, gated_a;
    logic       ack_b, en_b, gated_b;

    assign thr2 = thr[1:0];

    clk_gate_ctrl #(.IDLE_W(8), .WAKE_CYCLES(WAKE_CYCLES)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .sw_en_i(sw_en), .busy_i(busy),
        .idle_thr_i(thr), .wake_req_i(wake_req),
        .wake_ack_o(ack_a), .clk_en_o(en_a), .gated_o(gated_a)
    );

    clk_gate_ctrl #(.IDLE_W(2), .WAKE_CYCLES(WAKE_CYCLES)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .sw_en_i(sw_en), .busy_i(busy),
        .idle_thr_i(thr2), .wake_req_i(wake_req),
        .wake_ack_o(ack_b), .clk_en_o(en_b), .gated_o(gated_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: clock is either gated, settling (countdown of cycles left), or running.
    typedef struct {
        bit off;
        int settle_left;
        int idle_run;
        bit ack;
    } model_t;

    function automatic model_t model_step(model_t m, bit r, bit sw, bit bz, bit rq, int t);
        model_t n = m;
        bit     quiet;
        if (r) begin
            n.off = 0; n.settle_left = 0; n.idle_run = 0; n.ack = 0;
        end else if (m.off) begin
            n.ack = 0;
            if (rq || sw || bz) begin
                n.off = 0;
                n.settle_left = WAKE_CYCLES;
                n.idle_run = 0;
            end
        end else if (m.settle_left > 0) begin
            n.ack = 0;
            n.settle_left = m.settle_left - 1;
        end else begin
            quiet = !sw && !bz && !rq && (t != 0);
            n.ack = rq && !m.ack;
            if (quiet) begin
                n.idle_run = m.idle_run + 1;
                if (n.idle_run >= t) begin
                    n.off = 1;
                    n.idle_run = 0;
                end
            end else begin
                n.idle_run = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [2:0] model_out(model_t m);
        return {~m.off, m.off, m.ack};
    endfunction

    typedef struct {
        int cycles;
        int thr;     // -1: random threshold every cycle
        int p_busy;
        int p_sw;
        int p_req;
        int p_rst;
    } phase_t;

    phase_t phases[$];
    logic [2:0] exp_a_q[$];
    logic [2:0] exp_b_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial begin
        forever begin
            logic [2:0] e;
            @(posedge clk);
            #1;
            if (exp_a_q.size() > 0) begin
                e = exp_a_q.pop_front();
                checks++;
                if ({en_a, gated_a, ack_a} !== e)
                    $display("FAIL w8_outputs cycle %0d {en,gated,ack} got %b want %b",
                             cyc, {en_a, gated_a, ack_a}, e);
                if ({en_a, gated_a, ack_a} !== e) errors++;
            end
            if (exp_b_q.size() > 0) begin
                e = exp_b_q.pop_front();
                checks++;
                if ({en_b, gated_b, ack_b} !== e)
                    $display("FAIL w2_outputs cycle %0d {en,gated,ack} got %b want %b",
                             cyc, {en_b, gated_b, ack_b}, e);
                if ({en_b, gated_b, ack_b} !== e) errors++;
            end
        end
    end

    initial begin
        model_t ma, mb;
        ma = '{off: 0, settle_left: 0, idle_run: 0, ack: 0};
        mb = ma;
        rst = 1'b1; sw_en = 1'b0; busy = 1'b0; wake_req = 1'b0; thr = 8'd4;

        phases.push_back('{5,   4, 0,  0,   0,  100});  // reset
        phases.push_back('{12,  4, 0,  0,   0,  0});    // gate after 4 idle edges
        phases.push_back('{20,  4, 0,  0,   30, 0});    // wake requests from OFF
        phases.push_back('{3,   4, 0,  0,   0,  0});
        phases.push_back('{1,   4, 100, 0,  0,  0});    // busy pulse interrupting idle run
        phases.push_back('{10,  4, 0,  0,   0,  0});
        phases.push_back('{20,  4, 30, 0,   0,  0});
        phases.push_back('{100, 1, 0,  100, 0,  0});    // forced on
        phases.push_back('{10,  1, 0,  0,   0,  0});
        phases.push_back('{15,  1, 0,  100, 0,  0});    // force while gated
        phases.push_back('{300, 0, 0,  0,   0,  0});    // auto-gating disabled
        phases.push_back('{10,  1, 0,  0,   0,  0});
        phases.push_back('{40,  3, 0,  0,   0,  0});
        phases.push_back('{600, -1, 10, 5,  10, 2});
        phases.push_back('{600, -1, 3,  1,  5,  1});
        phases.push_back('{400, 3,  2,  0,  3,  1});
        phases.push_back('{400, -1, 20, 0,  40, 3});

        foreach (phases[pi]) begin
            for (int c = 0; c < phases[pi].cycles; c++) begin
                rst   = ($urandom_range(99) < phases[pi].p_rst);
                busy  = ($urandom_range(99) < phases[pi].p_busy);
                sw_en = ($urandom_range(99) < phases[pi].p_sw);
                thr   = (phases[pi].thr < 0) ? 8'($urandom_range(15)) : 8'(phases[pi].thr);
                // requester holds until acked, then may drop or keep holding
                if (wake_req && ma.ack) begin
                    if ($urandom_range(1) == 0) wake_req = 1'b0;
                end else if (!wake_req && ($urandom_range(99) < phases[pi].p_req)) begin
                    wake_req = 1'b1;
                end
                if (phases[pi].p_req == 0 && !(wake_req && !ma.ack)) wake_req = 1'b0;

                ma = model_step(ma, rst, sw_en, busy, wake_req, int'(thr));
                mb = model_step(mb, rst, sw_en, busy, wake_req, int'(thr2));
                exp_a_q.push_back(model_out(ma));
                exp_b_q.push_back(model_out(mb));

                @(posedge clk);
                #2;
                cyc++;
            end
        end

        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
